// File: rtl/formula_sum_isqrt_n_fsm.sv
// formula_sum_isqrt_n_fsm
//   Computes res = sum of isqrt(arg[i]) over NUM_ARGS unsigned arguments by
//   driving a pool of NUM_ISQRT external isqrt units. Arguments are issued in
//   batches of up to NUM_ISQRT; the lane results are accumulated as they return.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   arg_vld/rdy   argument handshake; args packed as arg[i] = args[i*ARG_W +: ARG_W]
//   res_vld, res  one-cycle result pulse, res holds until the next result
//   isqrt_x_vld   per-lane request pulse, isqrt_x per-lane operand
//   isqrt_y_vld   per-lane result valid, isqrt_y per-lane result (ARG_W/2 each)
//
// Build option
//   FORMULA_SUM_SAT_EN  defined: accumulator saturates at 2**RES_W-1
//                       undefined: accumulator wraps modulo 2**RES_W
//
// state | meaning
// IDLE  | ready for a new argument vector
// ISSUE | drive one batch of operands onto the isqrt lanes (one cycle)
// WAIT  | collect lane results of the current batch
// DONE  | publish the accumulator (one cycle)

module formula_sum_isqrt_n_fsm #(
  parameter int NUM_ARGS  = 3,
  parameter int NUM_ISQRT = 2,
  parameter int ARG_W     = 32,
  parameter int RES_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arg_vld,
  output logic                           arg_rdy,
  input  logic [NUM_ARGS*ARG_W-1:0]      args,
  output logic                           res_vld,
  output logic [RES_W-1:0]               res,
  output logic [NUM_ISQRT-1:0]           isqrt_x_vld,
  output logic [NUM_ISQRT*ARG_W-1:0]     isqrt_x,
  input  logic [NUM_ISQRT-1:0]           isqrt_y_vld,
  input  logic [NUM_ISQRT*(ARG_W/2)-1:0] isqrt_y
);

  localparam int Y_W   = ARG_W / 2;
  // idx can step one batch past NUM_ARGS before the final compare
  localparam int IDX_W = $clog2(NUM_ARGS + NUM_ISQRT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [NUM_ARGS*ARG_W-1:0]   args_q, args_d;
  logic [RES_W-1:0]            acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_ISQRT-1:0]        pend_q, pend_d;
  logic [RES_W-1:0]            res_q, res_d;
  logic                        res_vld_q, res_vld_d;

  logic [NUM_ISQRT-1:0]        lane_act;
  logic [RES_W-1:0]            acc_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      args_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      pend_q    <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      args_q    <= args_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  // Sum of every returning pending lane this cycle, applied one at a time so
  // saturation stays sticky across simultaneous returns.
  always_comb begin
    acc_sum = acc_q;
    for (int j = 0; j < NUM_ISQRT; j++) begin
      if (isqrt_y_vld[j] && pend_q[j]) begin
`ifdef FORMULA_SUM_SAT_EN
        logic [RES_W:0] sum_ext;
        sum_ext = {1'b0, acc_sum} + (RES_W+1)'(isqrt_y[j*Y_W +: Y_W]);
        acc_sum = sum_ext[RES_W] ? '1 : sum_ext[RES_W-1:0];
`else
        acc_sum = acc_sum + RES_W'(isqrt_y[j*Y_W +: Y_W]);
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    args_d    = args_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arg_vld) begin
          args_d  = args;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pend_d  = lane_act;
        idx_d   = idx_q + IDX_W'(NUM_ISQRT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        acc_d  = acc_sum;
        pend_d = pend_q & ~isqrt_y_vld;
        if (pend_d == '0) begin
          state_d = (int'(idx_q) < NUM_ARGS) ? S_ISSUE : S_DONE;
        end
      end
      S_DONE: begin
        res_d     = acc_q;
        res_vld_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane j carries arg[idx+j]; lanes past the last argument stay idle.
  always_comb begin
    arg_rdy  = (state_q == S_IDLE);
    res_vld  = res_vld_q;
    res      = res_q;
    lane_act = '0;
    isqrt_x  = '0;
    if (state_q == S_ISSUE) begin
      for (int j = 0; j < NUM_ISQRT; j++) begin
        for (int i = 0; i < NUM_ARGS; i++) begin
          if (int'(idx_q) + j == i) begin
            lane_act[j]                 = 1'b1;
            isqrt_x[j*ARG_W +: ARG_W]   = args_q[i*ARG_W +: ARG_W];
          end
        end
      end
    end
    isqrt_x_vld = lane_act;
  end

endmodule

// File: tb/tb_formula_sum_isqrt_n_fsm.sv
// Directed bench for formula_sum_isqrt_n_fsm. Three instances share clk/rst:
//   a: defaults, b: NUM_ARGS=5, c: RES_W=4. Each isqrt lane is served by a
//   behavioural responder with random (1..8) or forced latency.
module tb_formula_sum_isqrt_n_fsm;

  logic clk;
  logic rst;

  logic         arg_vld_a, arg_vld_b, arg_vld_c;
  logic         arg_rdy_a, arg_rdy_b, arg_rdy_c;
  logic [95:0]  args_a, args_c;
  logic [159:0] args_b;
  logic         res_vld_a, res_vld_b, res_vld_c;
  logic [31:0]  res_a, res_b;
  logic [3:0]   res_c;
  logic [1:0]   xv_a, xv_b, xv_c;
  logic [63:0]  x_a, x_b, x_c;
  logic [1:0]   yv_a, yv_b, yv_c;
  logic [31:0]  y_a, y_b, y_c;

  logic [5:0]   xv_all;
  logic [191:0] x_all;
  int           lat_cfg [6];

  int total = 0;
  int bad   = 0;
  int np_a = 0, np_b = 0, np_c = 0;
  logic [1:0] log_a[$];
  logic [1:0] log_b[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  formula_sum_isqrt_n_fsm u_a (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_a), .arg_rdy(arg_rdy_a), .args(args_a),
    .res_vld(res_vld_a), .res(res_a), .isqrt_x_vld(xv_a), .isqrt_x(x_a),
    .isqrt_y_vld(yv_a), .isqrt_y(y_a));

  formula_sum_isqrt_n_fsm #(.NUM_ARGS(5)) u_b (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_b), .arg_rdy(arg_rdy_b), .args(args_b),
    .res_vld(res_vld_b), .res(res_b), .isqrt_x_vld(xv_b), .isqrt_x(x_b),
    .isqrt_y_vld(yv_b), .isqrt_y(y_b));

  formula_sum_isqrt_n_fsm #(.RES_W(4)) u_c (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_c), .arg_rdy(arg_rdy_c), .args(args_c),
    .res_vld(res_vld_c), .res(res_c), .isqrt_x_vld(xv_c), .isqrt_x(x_c),
    .isqrt_y_vld(yv_c), .isqrt_y(y_c));

  function automatic logic [15:0] isqrt32(input logic [31:0] v);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if ({32'd0, t} * {32'd0, t} <= {32'd0, v}) r = t;
    end
    return r;
  endfunction

  assign xv_all = {xv_c, xv_b, xv_a};
  assign x_all  = {x_c, x_b, x_a};

  for (genvar k = 0; k < 6; k++) begin : ln
    logic        xv;
    logic [31:0] x;
    logic        yv;
    logic [15:0] y;
    logic [31:0] op_q;
    logic [3:0]  rnd;
    int          cnt;
    int          lat_use;
    assign xv      = xv_all[k];
    assign x       = x_all[k*32 +: 32];
    assign lat_use = (lat_cfg[k] != 0) ? lat_cfg[k] : int'(rnd);
    always @(posedge clk) rnd <= 4'($urandom_range(8, 1));
    always @(posedge clk) begin
      if (rst) begin
        cnt <= 0;
        yv  <= 1'b0;
        y   <= 16'hBEEF;
      end else if (xv) begin
        op_q <= x;
        if (lat_use == 1) begin
          yv  <= 1'b1;
          y   <= isqrt32(x);
          cnt <= 0;
        end else begin
          yv  <= 1'b0;
          y   <= 16'hBEEF;
          cnt <= lat_use - 1;
        end
      end else if (cnt == 1) begin
        yv  <= 1'b1;
        y   <= isqrt32(op_q);
        cnt <= 0;
      end else begin
        yv <= 1'b0;
        y  <= 16'hBEEF;
        if (cnt > 1) cnt <= cnt - 1;
      end
    end
  end

  assign yv_a = {ln[1].yv, ln[0].yv};
  assign y_a  = {ln[1].y,  ln[0].y};
  assign yv_b = {ln[3].yv, ln[2].yv};
  assign y_b  = {ln[3].y,  ln[2].y};
  assign yv_c = {ln[5].yv, ln[4].yv};
  assign y_c  = {ln[5].y,  ln[4].y};

  always @(posedge clk) begin
    if (res_vld_a) np_a <= np_a + 1;
    if (res_vld_b) np_b <= np_b + 1;
    if (res_vld_c) np_c <= np_c + 1;
    if (xv_a != 2'b00) log_a.push_back(xv_a);
    if (xv_b != 2'b00) log_b.push_back(xv_b);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic get_rv(input int d);
    return (d == 0) ? res_vld_a : (d == 1) ? res_vld_b : res_vld_c;
  endfunction

  function automatic logic get_rdy(input int d);
    return (d == 0) ? arg_rdy_a : (d == 1) ? arg_rdy_b : arg_rdy_c;
  endfunction

  function automatic logic [63:0] get_res(input int d);
    return (d == 0) ? 64'(res_a) : (d == 1) ? 64'(res_b) : 64'(res_c);
  endfunction

  task automatic drive_args(input int d, input logic [159:0] av, input logic v);
    case (d)
      0: begin args_a = av[95:0]; arg_vld_a = v; end
      1: begin args_b = av;       arg_vld_b = v; end
      default: begin args_c = av[95:0]; arg_vld_c = v; end
    endcase
  endtask

  // Accept cycle is counted as cycle 0; lat is the cycle in which res_vld is seen.
  task automatic run_op(input int d, input logic [159:0] av, input bit hold,
                        input logic [159:0] av2, output int lat, output logic [63:0] r);
    @(negedge clk);
    drive_args(d, av, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("busy_rdy", 64'(get_rdy(d)), 64'd0);
        drive_args(d, hold ? av2 : av, hold);
      end
    end while (!get_rv(d) && lat < 300);
    drive_args(d, av, 1'b0);
    chk("res_vld_seen", 64'(get_rv(d)), 64'd1);
    r = get_res(d);
  endtask

  int          lat;
  logic [63:0] r;
  int          base;
  int          np0;

  initial begin
    rst = 1'b1;
    arg_vld_a = 1'b0; arg_vld_b = 1'b0; arg_vld_c = 1'b0;
    args_a = '0; args_b = '0; args_c = '0;
    for (int i = 0; i < 6; i++) lat_cfg[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdy",     64'(arg_rdy_a), 64'd1);
    chk("rst_res_vld", 64'(res_vld_a), 64'd0);
    chk("rst_res",     64'(res_a),     64'd0);
    chk("rst_xvld",    64'(xv_a),      64'd0);
    rst = 1'b0;

    // 16,25,36 -> 4+5+6
    base = log_a.size(); np0 = np_a;
    run_op(0, {64'd0, 32'd36, 32'd25, 32'd16}, 1'b0, '0, lat, r);
    chk("t1_res", r, 64'd15);
    repeat (5) @(negedge clk);
    chk("t1_pulses",  64'(np_a - np0),        64'd1);
    chk("t1_batches", 64'(log_a.size() - base), 64'd2);
    chk("t1_xvld0",   64'(log_a[base]),       64'd3);
    chk("t1_xvld1",   64'(log_a[base+1]),     64'd1);

    // five args over two lanes -> three batches; 1+2+3+4+5
    base = log_b.size();
    run_op(1, {32'd25, 32'd16, 32'd9, 32'd4, 32'd1}, 1'b0, '0, lat, r);
    chk("t2_res", r, 64'd15);
    repeat (2) @(negedge clk);
    chk("t2_batches", 64'(log_b.size() - base), 64'd3);
    chk("t2_xvld0",   64'(log_b[base]),       64'd3);
    chk("t2_xvld1",   64'(log_b[base+1]),     64'd3);
    chk("t2_xvld2",   64'(log_b[base+2]),     64'd1);

    // lane1 returns 5 cycles ahead of lane0; 0+65535+1; latency (1+7)+(1+7)+2
    lat_cfg[0] = 7; lat_cfg[1] = 2;
    run_op(0, {64'd0, 32'd1, 32'hFFFF_FFFF, 32'd0}, 1'b0, '0, lat, r);
    chk("t3_res", r, 64'd65536);
    chk("t3_latency", 64'(lat), 64'd18);
    lat_cfg[0] = 0; lat_cfg[1] = 0;

    // arg_vld held high with new args while busy: 7+8+9 only, single pulse
    repeat (2) @(negedge clk);
    base = log_a.size(); np0 = np_a;
    run_op(0, {64'd0, 32'd81, 32'd64, 32'd49}, 1'b1, {64'd0, 32'd1, 32'd1, 32'd1}, lat, r);
    chk("t4_res", r, 64'd24);
    repeat (20) @(negedge clk);
    chk("t4_pulses",  64'(np_a - np0),          64'd1);
    chk("t4_batches", 64'(log_a.size() - base), 64'd2);
    chk("t4_res_hold", 64'(res_a), 64'd24);

    // reset while waiting on the first batch aborts the operation
    lat_cfg[0] = 8; lat_cfg[1] = 8;
    @(negedge clk);
    drive_args(0, {64'd0, 32'd100, 32'd100, 32'd100}, 1'b1);
    @(negedge clk);
    drive_args(0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rdy_after_rst", 64'(arg_rdy_a), 64'd1);
    chk("t5_res_after_rst", 64'(res_a),     64'd0);
    np0 = np_a;
    repeat (20) @(negedge clk);
    chk("t5_no_pulse", 64'(np_a - np0), 64'd0);
    lat_cfg[0] = 0; lat_cfg[1] = 0;
    run_op(0, {64'd0, 32'd16, 32'd9, 32'd4}, 1'b0, '0, lat, r);
    chk("t5_res", r, 64'd9);

    // RES_W=4: 10+10+10 = 30 -> saturate to 15 or wrap to 14
    run_op(2, {64'd0, 32'd100, 32'd100, 32'd100}, 1'b0, '0, lat, r);
`ifdef FORMULA_SUM_SAT_EN
    chk("t6_res_sat", r, 64'd15);
`else
    chk("t6_res_wrap", r, 64'd14);
`endif
    repeat (3) @(negedge clk);
    chk("t6_pulses", 64'(np_c), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
